// File: rtl/sr_cmd_gen.sv
// Purpose : synchronise and debounce raw set/clear requests into exclusive one-cycle s/r pulses for a downstream SR flop.
// Latency : a raw rise first sampled at edge n pulses s/r at edge n+DEB_CYCLES+3; pulses are spaced by at least GAP_CYCLES+1 edges.
// Backpress: no handshake; events arriving during the gap are held in a one-deep pending slot in which the latest event wins.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-low reset
//   set_req   - raw set request, asynchronous to clk
//   clr_req   - raw clear request, asynchronous to clk
//   s, r      - one-cycle set / reset pulses; never high together
//   busy      - high during the forced idle cycles that follow each pulse
//   conflict  - one-cycle flag: set and clear events accepted on the same edge
//   q_exp     - mirror of the flop state that the issued pulses produce
//
// Optional build macro SR_CMD_SET_PRIORITY_EN: when defined, a simultaneous
// set/clear event resolves to set; otherwise both events are dropped.
module sr_cmd_gen #(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic q_exp
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {CMD_NONE, CMD_SET, CMD_CLR} cmd_t;
  typedef enum logic {ST_IDLE, ST_GAP} state_t;

  // Channel 0 carries set, channel 1 carries clear.
  logic [1:0]         raw;
  logic [1:0]         sync1;
  logic [1:0]         sync2;
  logic [1:0]         deb;
  logic [1:0]         deb_d;
  logic [1:0]         evt;
  logic [1:0][DW-1:0] cnt;

  assign raw = {clr_req, set_req};

  // Synchroniser, debouncer and rising-edge detector for both channels.
  // The counter measures how long the synchronised input has disagreed
  // with the accepted level; a single agreeing sample restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      evt   <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Registered edge detect: one extra stage between debouncer and FSM.
      evt   <= deb & ~deb_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t      state;
  logic [GW-1:0] gcnt;
  cmd_t        pend;
  cmd_t        evt_cmd;
  cmd_t        issue_cmd;
  logic        both_evt;

  // Resolve this edge's events into at most one command.
  always_comb begin
    both_evt = evt[0] & evt[1];
    evt_cmd  = CMD_NONE;
    if (both_evt) begin
`ifdef SR_CMD_SET_PRIORITY_EN
      evt_cmd = CMD_SET;
`else
      evt_cmd = CMD_NONE;
`endif
    end else if (evt[0]) begin
      evt_cmd = CMD_SET;
    end else if (evt[1]) begin
      evt_cmd = CMD_CLR;
    end
  end

  // A fresh event on the issuing edge beats whatever was pending; in IDLE
  // pend is always NONE so this is simply the fresh event.
  assign issue_cmd = (evt_cmd != CMD_NONE) ? evt_cmd : pend;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      gcnt     <= '0;
      pend     <= CMD_NONE;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      q_exp    <= 1'b0;
    end else begin
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      conflict <= both_evt;

      if (s) begin
        q_exp <= 1'b1;
      end else if (r) begin
        q_exp <= 1'b0;
      end

      if (state == ST_GAP && gcnt != '0) begin
        // Forced idle: count down and remember only the newest command.
        gcnt <= gcnt - 1'b1;
        busy <= 1'b1;
        if (evt_cmd != CMD_NONE) begin
          pend <= evt_cmd;
        end
      end else begin
        // IDLE, or the gap has expired: issue if anything is waiting.
        pend <= CMD_NONE;
        if (issue_cmd != CMD_NONE) begin
          s     <= (issue_cmd == CMD_SET);
          r     <= (issue_cmd == CMD_CLR);
          state <= ST_GAP;
          gcnt  <= GW'(GAP_CYCLES);
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/sr_cmd_gen.md
# sr_cmd_gen

Command front-end placed directly upstream of the SR flip-flop. It takes two raw, asynchronous request lines (set and clear), then synchronizes and debounces them. It converts each debounced rising edge into a one-cycle `s` or `r` pulse, and enforces a minimum gap between commands. It guarantees `s` and `r` are never high together, so the downstream flop never sees the `11` input. An expected-state mirror output is provided for checking the flop's `q`.

## Interface
- `DEB_CYCLES`, default 4: consecutive stable cycles needed to accept a level change; legal range 1..255.
- `GAP_CYCLES`, default 3: idle cycles forced after every issued pulse; legal range 1..255.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
- `set_req`  in  1  raw set request, asynchronous to `clk`.
- `clr_req`  in  1  raw clear request, asynchronous to `clk`.
- `s`  out  1  one-cycle set pulse to the flop.
- `r`  out  1  one-cycle reset pulse to the flop.
- `busy`  out  1  high while in GAP.
- `conflict`  out  1  one-cycle flag: set and clear events accepted on the same edge.
- `q_exp`  out  1  expected flop state.

## Operation
- Per input:
  - A 2-flop synchronizer feeds a debouncer with counter width ceil(log2(DEB_CYCLES+1)).
  - The counter increments on each edge where the synchronizer output ≠ the debounced level, and clears when they are equal.
  - When the counter would reach DEB_CYCLES, the debounced level toggles and the counter clears.
- Event = debounced 0→1 transition. Falling transitions generate nothing.
- FSM states:
  - IDLE:
    - A set event drives `s`=1 on the next edge.
    - A clear event drives `r`=1 on the next edge.
    - After either, the FSM goes to GAP with the gap counter loaded to GAP_CYCLES.
  - GAP:
    - `s`=`r`=0 and `busy`=1.
    - Events arriving here are stored in a one-deep pending register (NONE/SET/CLR); the latest event overwrites.
    - The counter decrements each edge.
    - At 0, if pending ≠ NONE, the pending command is issued exactly as from IDLE, pending clears, and GAP reloads.
    - At 0 with no pending command, the FSM goes to IDLE.
- Simultaneous set and clear events on the same edge, in any state:
  - `conflict`=1 for one cycle.
  - Resolution depends on the macro (see Configuration).
- `q_exp`:
  - Becomes 1 on the edge after `s`=1 and 0 on the edge after `r`=1; it tracks the downstream flop's `q`.
  - It holds otherwise.
- `s` and `r` are never both 1. This is invariant.

## Timing
- Reset values (while `rst`=0, asynchronously):
  - `s`=0, `r`=0, `busy`=0, `conflict`=0, `q_exp`=0.
  - Synchronizers, debounced levels and counters = 0; pending = NONE; FSM = IDLE.
- Latency from IDLE:
  - A raw rise first sampled at edge n gives `s`/`r` high at edge n+DEB_CYCLES+3 (7 edges with the defaults).
  - The pulse lasts exactly 1 cycle.
- Gap:
  - After a pulse, `s`/`r` stay low for at least GAP_CYCLES cycles.
  - The next pulse starts no earlier than GAP_CYCLES+1 edges after the previous one.
- Glitches shorter than DEB_CYCLES cycles, measured after the synchronizer, are ignored. They cause no change in the debounced level and no pulse.
- A raw input held high through reset release is seen as a fresh 0→1 edge. It produces one pulse DEB_CYCLES+3 edges after the first clock following deassertion.
- Reset asserted mid-GAP or mid-pulse:
  - All outputs drop immediately.
  - The pending command is discarded.
- Holding a request high produces exactly one pulse; a new pulse requires release (debounced) and then re-press.

## Configuration
- `SR_CMD_SET_PRIORITY_EN`
  - Defined: on a simultaneous event, set wins. SET is issued, or stored as pending in GAP, and `conflict` still pulses.
  - Undefined: both events are dropped, pending is unchanged, and only `conflict` pulses.

## Test plan
- Reset, then pulse `set_req` high from cycle 10 to cycle 30 → `s`=1 for one cycle at edge 17, `q_exp`=1 from edge 18, `busy`=1 for the following 3 cycles.
- Pulse `clr_req` high for 2 cycles, which is shorter than DEB_CYCLES → no `r` pulse, `q_exp` unchanged.
- Issue set, then a clear event lands during GAP → `r` is issued exactly GAP_CYCLES+1 edges after `s`. A set followed by a clear within the same GAP → only the clear issues (latest wins).
- Rise `set_req` and `clr_req` on the same cycle:
  - Without the macro → `conflict`=1 once and no `s`/`r`.
  - With the macro → `conflict`=1 and `s`=1 on the same edge.
- Assert `rst`=0 mid-GAP with a command pending → `busy`, `s`, `r` and `q_exp` are 0 immediately, and no pulse follows after release while the inputs stay low.
- Random request streams for 10k cycles → assert `s`&`r` is never 1, and check `q_exp` against the downstream flop's `q`.
